// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Purpose  : Iterative 32x32 multiply / 32/32 divide unit owning the MIPS
//            HI/LO registers. One result bit per cycle, 33-cycle latency.
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] mt_data,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_CALC = 2'd1;
  localparam logic [1:0] c_FIX  = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [4:0]  r_cnt;
  logic        r_is_div;
  logic [31:0] r_b;          // multiplicand for multiply, divisor for divide
  logic [63:0] r_acc;        // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic        r_neg_q;      // negate product / quotient at the end
  logic        r_neg_r;      // negate remainder (dividend was negative)
  logic        r_divz;
  logic [31:0] r_rs_orig;
  logic        r_done;
  logic        r_div_zero;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  // op[0]==0 selects the signed flavours (MULT, DIV)
  logic        w_signed;
  logic [31:0] w_rs_mag;
  logic [31:0] w_rt_mag;
  logic        w_launch;

  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_acc;
  logic [32:0] w_div_shift;
  logic        w_div_ge;
  logic [31:0] w_div_diff;
  logic [63:0] w_div_acc;

  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;

  assign w_signed = ~op[0];
  assign w_rs_mag = (w_signed && rs_data[31]) ? -rs_data : rs_data;
  assign w_rt_mag = (w_signed && rt_data[31]) ? -rt_data : rt_data;
  assign w_launch = (r_state == c_IDLE) && start;

  // Shift-add step: conditionally add multiplicand to the upper half, then shift right
  assign w_mul_sum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
  assign w_mul_acc = {w_mul_sum, r_acc[31:1]};

  // Restoring divide step: remainder < divisor, so the shifted value fits 33 bits
  // and a successful subtraction always fits back into 32 bits.
  assign w_div_shift = {r_acc[63:32], r_acc[31]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_b});
  assign w_div_diff  = w_div_shift[31:0] - r_b;
  assign w_div_acc   = {(w_div_ge ? w_div_diff : w_div_shift[31:0]), r_acc[30:0], w_div_ge};

  // Sign correction and special-case mapping applied in FIX
  always_comb begin
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    if (!r_is_div) begin
      {w_res_hi, w_res_lo} = r_neg_q ? -r_acc : r_acc;
    end else if (r_divz) begin
      w_res_hi = r_rs_orig;
      w_res_lo = 32'hFFFF_FFFF;
    end else begin
      w_res_lo = r_neg_q ? -r_acc[31:0]  : r_acc[31:0];
      w_res_hi = r_neg_r ? -r_acc[63:32] : r_acc[63:32];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (start) w_state_nxt = c_CALC;
      c_CALC:  if (r_cnt == 5'd31) w_state_nxt = c_FIX;
      c_FIX:   w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    busy     = (r_state == c_CALC) || (r_state == c_FIX);
    done     = r_done;
    div_zero = r_div_zero;
    hi       = r_hi;
    lo       = r_lo;
  end

  // Operand latch and iteration datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= 5'd0;
      r_is_div  <= 1'b0;
      r_b       <= 32'd0;
      r_acc     <= 64'd0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_divz    <= 1'b0;
      r_rs_orig <= 32'd0;
    end else if (w_launch) begin
      r_cnt     <= 5'd0;
      r_is_div  <= op[1];
      r_b       <= op[1] ? w_rt_mag : w_rs_mag;
      r_acc     <= {32'd0, (op[1] ? w_rs_mag : w_rt_mag)};
      r_neg_q   <= w_signed && (rs_data[31] ^ rt_data[31]);
      r_neg_r   <= w_signed && rs_data[31];
      r_divz    <= op[1] && (rt_data == 32'd0);
      r_rs_orig <= rs_data;
    end else if (r_state == c_CALC) begin
      r_cnt <= r_cnt + 5'd1;
      r_acc <= r_is_div ? w_div_acc : w_mul_acc;
    end
  end

  // HI/LO update: result in FIX, MTHI/MTLO only while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done     <= (r_state == c_FIX);
      r_div_zero <= (r_state == c_FIX) && r_divz;
      if (r_state == c_FIX) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end else if (r_state == c_IDLE) begin
        if (mthi) r_hi <= mt_data;
        if (mtlo) r_lo <= mt_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_unit
// Purpose  : Directed scoreboard bench for mult_div_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        mthi;
  logic        mtlo;
  logic [31:0] mt_data;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  mult_div_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .mthi     (mthi),
    .mtlo     (mtlo),
    .mt_data  (mt_data),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
    exp_t e;
    e.hi = ehi;
    e.lo = elo;
    e.dz = edz;
    exp_q.push_back(e);
  endtask

  // Drive start for one edge; returns at #1 after the sampling edge
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op      = o;
    rs_data = a;
    rt_data = b;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  // Count busy cycles until done appears (bounded); returns in the done cycle
  task automatic wait_done(input string name, output int cyc);
    int k;
    cyc = 0;
    k   = 0;
    while (!done && k < 200) begin
      if (busy) cyc++;
      @(posedge clk); #1;
      k++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: timeout actual=no_done expected=done", name);
    end
  endtask

  // Monitor: compare every done pulse against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy && done) chk("busy_and_done", {busy, done}, 2'b01);
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", {31'd0, done}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("result_hi", hi, e.hi);
          chk("result_lo", lo, e.lo);
          chk("result_div_zero", {31'd0, div_zero}, {31'd0, e.dz});
        end
      end
    end
  end

  initial begin
    int cyc;
    rst_n   = 1'b0;
    start   = 1'b0;
    op      = 2'd0;
    rs_data = 32'd0;
    rt_data = 32'd0;
    mthi    = 1'b0;
    mtlo    = 1'b0;
    mt_data = 32'd0;

    // Reset state
    #3;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_div_zero", {31'd0, div_zero}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // MULTU max x max: latency and pulse width
    push(32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max", cyc);
    chk("multu_busy_cycles", cyc, 32'd33);
    @(posedge clk); #1;
    chk("done_width", {31'd0, done}, 32'd0);

    // Signed multiply and divide
    push(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    launch(2'b00, 32'hFFFF_FFFD, 32'd7);
    wait_done("mult_neg", cyc);
    @(posedge clk); #1;
    push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    launch(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg", cyc);
    @(posedge clk); #1;

    // Divide by zero and the overflow case
    push(32'd100, 32'hFFFF_FFFF, 1'b1);
    launch(2'b11, 32'd100, 32'd0);
    wait_done("divu_zero", cyc);
    chk("divz_busy_cycles", cyc, 32'd33);
    @(posedge clk); #1;
    push(32'd0, 32'h8000_0000, 1'b0);
    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", cyc);
    @(posedge clk); #1;

    // Start while busy ignored; start in done cycle accepted
    push(32'd1, 32'd7, 1'b0);
    launch(2'b11, 32'd50, 32'd7);
    repeat (9) begin @(posedge clk); #1; end
    launch(2'b01, 32'd5, 32'd6);
    wait_done("divu_50_7", cyc);
    push(32'd0, 32'd30, 1'b0);
    launch(2'b01, 32'd5, 32'd6);
    wait_done("multu_in_done_cycle", cyc);
    chk("back_to_back_busy_cycles", cyc, 32'd33);
    @(posedge clk); #1;

    // MTHI/MTLO in idle
    mthi = 1'b1; mtlo = 1'b1; mt_data = 32'h1234_5678;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    chk("mthi_idle", hi, 32'h1234_5678);
    chk("mtlo_idle", lo, 32'h1234_5678);

    // MT write coincident with start lands; MT write while busy ignored
    mthi = 1'b1; mtlo = 1'b1; mt_data = 32'hCAFE_F00D;
    push(32'd0, 32'd6, 1'b0);
    launch(2'b01, 32'd2, 32'd3);
    mt_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    chk("mthi_with_start", hi, 32'hCAFE_F00D);
    chk("mtlo_while_busy", lo, 32'hCAFE_F00D);
    wait_done("multu_2_3", cyc);
    @(posedge clk); #1;

    // Asynchronous reset mid-operation
    launch(2'b01, 32'h0001_0000, 32'h0001_0000);
    repeat (19) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) begin @(posedge clk); #1; end
    chk("abort_idle_busy", {31'd0, busy}, 32'd0);

    push(32'd0, 32'd12, 1'b0);
    launch(2'b01, 32'd3, 32'd4);
    wait_done("multu_after_reset", cyc);
    @(posedge clk); #1;

    // Drain scoreboard
    begin
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 100) begin
        @(posedge clk); #1;
        k++;
      end
    end
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative MIPS multiply/divide unit owning the HI/LO special registers. It sits directly downstream of the register file's read ports. It consumes the rs/rt operand values for MULT, MULTU, DIV and DIVU and holds the 64-bit result in HI/LO for later MFHI/MFLO. MTHI/MTLO writes are also accepted. The core stalls on `busy` and samples results on `done`.

## Interface
Parameters: none (datapath fixed at 32 bits; iteration count fixed at 32).

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  launch operation `op` on `rs_data`/`rt_data`; honoured only in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`
- rs_data  in  32  operand A (multiplicand / dividend), from register file read_data_1
- rt_data  in  32  operand B (multiplier / divisor), from register file read_data_2
- mthi  in  1  write `mt_data` into HI; honoured only in IDLE
- mtlo  in  1  write `mt_data` into LO; honoured only in IDLE
- mt_data  in  32  MTHI/MTLO data
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse: HI/LO just updated with a result
- div_zero  out  1  one-cycle pulse coincident with `done` for DIV/DIVU with rt_data==0
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- States: IDLE, CALC, FIX.
- IDLE + start -> CALC.
  - Operands latched as unsigned magnitudes; signed ops record the operand signs.
  - Iteration counter cleared; busy=1.
- CALC runs 32 iterations, one per cycle, with the counter going 0..31. After iteration 31 -> FIX.
  - Multiply: shift-add over the 64-bit accumulator.
  - Divide: restoring, one quotient bit per cycle, 32-bit remainder.
- FIX lasts one cycle: sign correction, HI/LO written, done=1 → IDLE, busy=0.
- Result mapping:
  - MULT/MULTU: {hi,lo} = 64-bit product. MULT negates the magnitude product if the operand signs differ.
  - DIV/DIVU: lo = quotient, hi = remainder.
  - DIV quotient is negative iff the signs differ; the remainder takes the dividend's sign (truncation toward zero).
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000 (wraps, no flag).
- Divide by zero (rt_data==0, DIV or DIVU): full 33-cycle latency still applies.
  - Result: lo=0xFFFFFFFF, hi = original rs_data.
  - div_zero pulses with done.
- mthi/mtlo:
  - In IDLE, the register updates at the next edge; both may be asserted together.
  - If asserted in the same cycle as start, the write still takes effect, and the later result overwrites it.
  - Ignored while busy.
- start while busy is ignored: no queueing, operands not re-latched.

## Timing
- Reset (async assert, any state): state=IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, counter=0.
  - Reset mid-operation aborts; no partial result reaches HI/LO.
- Edge E0 samples start=1 in IDLE. busy is high from after E0 until after E33.
- HI/LO take the result at E33. done and div_zero are high for the single cycle after E33.
  - Latency from start to done: 33 cycles.
- busy and done are never high together.
- start may be asserted in the cycle where done=1, since the unit is already IDLE. It is accepted: done drops and busy rises after that edge.
- hi/lo are stable and valid whenever busy=0. While busy, they hold their previous values.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- MULTU, rs=0xFFFFFFFF, rt=0xFFFFFFFF → after 33 cycles: hi=0xFFFFFFFE, lo=0x00000001, done pulse width 1, busy high exactly 33 cycles.
- MULT, rs=0xFFFFFFFD (−3), rt=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV, rs=0xFFFFFFF9 (−7), rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU, rs=100, rt=0 → lo=0xFFFFFFFF, hi=100, div_zero=1 with done. Also DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Pulse start (MULTU 5×6) at cycle 10 of a running DIVU 50/7 → result is lo=7, hi=1; no second done.
  - New start in the done cycle is accepted: second result lands 33 cycles later.
- mthi=1, mtlo=1, mt_data=0x12345678 in IDLE → hi=lo=0x12345678 next cycle.
  - The same write while busy → no change.
- Assert rst_n=0 asynchronously at cycle 20 of a MULTU → busy, done, hi and lo drop to 0 immediately, with no done afterward.
  - After release, a fresh MULTU 3×4 yields lo=12, hi=0.
